cond_mac_seq: RTL and testbench
===============================

// Module: cond_mac_seq
// PURPOSE
//  Parametrised sequential conditional multiply-accumulate engine over two DEPTH-entry signed fixed-point arrays a[] and b[].
//  It replaces the unrolled per-element mul/add/if-else chain with one multiplier and an FSM.
//  It uses the same start/valid/busy handshake as mul_always and addition_always, so a generated top instantiates it directly.
// PARAMETERS
//  WIDTH  32  data width, signed two's complement
//  FRAC   16  fractional bits (Q(WIDTH-FRAC).FRAC; 1.0 = 1<<FRAC)
//  DEPTH  5   array entries (>=1)
//  AW     $clog2(DEPTH) (min 1)  address width
// PORTS
//  clk      in   1       rising-edge clock
//  reset    in   1       synchronous, active-high
//  start    in   1       launch; sampled only in IDLE
//  wr_en    in   1       array write strobe
//  wr_sel   in   1       0 = write a[], 1 = write b[]
//  wr_addr  in   AW      entry index
//  wr_data  in   WIDTH   entry value
//  c        in   WIDTH   accumulator seed, captured at start
//  mode     in   2       0 = MAC; 1 = cond add/sub; 2 = cond add/hold; 3 = same as 0. Captured at start.
//  len      in   AW+1    element count; 0 or >DEPTH clamps to DEPTH. Captured at start.
//  result   out  WIDTH   final accumulator; holds until next start
//  valid    out  1       one-cycle pulse when result is updated
//  busy     out  1       high while computing
// BEHAVIOUR
//  Reset: state=IDLE, result=0, valid=0, busy=0, idx=0, x=0, p=0. a[]/b[] are not reset and retain their contents.
//  Writes: accepted only when !busy. wr_addr>=DEPTH is ignored. A write committed on the start edge is visible to the run.
//  FSM states: IDLE -> MUL -> ACC -> (MUL | DONE) -> IDLE.
//   IDLE: start=1 -> x<=c, latch mode/len, idx<=0, go to MUL.
//   MUL:  p <= (a[idx]*b[idx]) >>> FRAC. The full 2*WIDTH signed product is truncated to WIDTH.
//   ACC:  cond = ($signed(a[idx]) > $signed(x)).
//         mode 0/3: x<=x+p
//         mode 1:   x <= cond ? x+p : x-p
//         mode 2:   x <= cond ? x+p : x
//         Then idx++. If idx == len-1, go to DONE.
//   DONE: result<=x, valid=1 for this cycle only, go to IDLE.
//  Timing: start high at cycle t -> busy high for cycles t+1..t+2*len; valid high at t+2*len+1 with busy=0.
//  Adds and subtracts wrap modulo 2^WIDTH unless COND_MAC_SAT_EN is defined.
//  start while busy or in DONE is ignored; no queueing. start in the cycle after valid launches a new run.
//  Reset mid-run aborts immediately. The next cycle shows IDLE, busy=0, valid=0, result=0.
// CONFIGURATION
//  `COND_MAC_SAT_EN defined:
//   - Product saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] after the shift.
//   - Every accumulator add/sub saturates to the same range.
//  Not defined: plain truncation and wrap. No saturation logic is generated.
// STRUCTURE
//  cond_mac_pkg holds:
//   - state enum (S_IDLE, S_MUL, S_ACC, S_DONE)
//   - mode constants (MODE_MAC, MODE_ADDSUB, MODE_ADDHOLD)
//   - sat_add / sat_sub functions
//  One sub-module, cond_mac_fxmul: registered signed WIDTHxWIDTH multiply with >>>FRAC. Its saturation is gated by the same macro.
//  a[], b[] are register arrays with asynchronous read by idx.
// TESTING
//  Common setup unless stated: DEPTH=5, FRAC=16, c=0, len=0 (clamps to 5).
//  1. a={1..5}<<16, b={7..11}<<16, mode=0, start at t
//     -> busy t+1..t+10, valid at t+11, result=145<<16=9502720.
//  2. Same arrays, mode=1 -> x: 7,-9,18,-22,33; result=33<<16=2162688.
//     Same arrays, mode=2 -> result=7<<16=458752.
//  3. a[0]=b[0]=32'h7FFF0000, other entries 0, mode=0
//     -> with COND_MAC_SAT_EN: result=32'h7FFFFFFF; without it: result=32'h00010000.
//  4. len=2, scenario-1 arrays -> valid at t+5, result=23<<16.
//     len=7 -> clamps to 5, same result as scenario 1.
//  5. Reset at t+4 of a run -> at t+5 busy=0, valid=0, result=0.
//     A fresh start then reproduces scenario 1 exactly.
//  6. Pulse start and wr_en (a[0]=0) mid-run -> both ignored; result unchanged vs scenario 1; a[0] still 1<<16.

Source files
------------

// File: rtl/cond_mac_pkg.sv
// Shared types, mode encodings and saturating arithmetic helpers for cond_mac_seq.
// The helpers operate on a 65-bit signed container so any WIDTH up to 64 can use them.
package cond_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_MAC     = 2'd0;
  localparam logic [1:0] MODE_ADDSUB  = 2'd1;
  localparam logic [1:0] MODE_ADDHOLD = 2'd2;

  localparam int MAX_W = 64;

  typedef logic signed [MAX_W:0]   wide_t;
  typedef logic signed [MAX_W+1:0] ext_t;

  // Clamp v into the signed range of a w-bit word.
  function automatic wide_t sat_clamp(input ext_t v, input int w);
    ext_t  hi;
    ext_t  lo;
    wide_t r;
    hi = $signed((66'd1 << (w - 1)) - 66'd1);
    lo = -hi - 66'sd1;
    if (v > hi) begin
      r = hi[MAX_W:0];
    end else if (v < lo) begin
      r = lo[MAX_W:0];
    end else begin
      r = v[MAX_W:0];
    end
    return r;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    return sat_clamp(ext_t'(a) + ext_t'(b), w);
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int w);
    return sat_clamp(ext_t'(a) - ext_t'(b), w);
  endfunction

endpackage

// File: rtl/cond_mac_fxmul.sv
// Registered signed fixed-point multiply: p <= (a*b) >>> FRAC, truncated to WIDTH.
// With COND_MAC_SAT_EN defined the shifted product saturates instead of truncating.
module cond_mac_fxmul #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [WIDTH-1:0] p_s;

`ifdef COND_MAC_SAT_EN
  localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] shr_s;

  assign shr_s = ((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC;

  // Clamp the shifted product into the WIDTH-bit range.
  always_comb begin
    if (shr_s > P_MAX) begin
      p_s = P_MAX[WIDTH-1:0];
    end else if (shr_s < P_MIN) begin
      p_s = P_MIN[WIDTH-1:0];
    end else begin
      p_s = shr_s[WIDTH-1:0];
    end
  end
`else
  // Keep only the low WIDTH bits of the shifted product.
  always_comb begin
    p_s = WIDTH'(((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC);
  end
`endif

  // Product register, loaded only in the multiply phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= {WIDTH{1'b0}};
    end else if (en) begin
      p <= p_s;
    end else begin
      p <= p;
    end
  end

endmodule

// File: rtl/cond_mac_seq.sv
// Sequential conditional multiply-accumulate over two DEPTH-entry fixed-point arrays.
// Define COND_MAC_SAT_EN to saturate products and accumulator updates instead of wrapping.
module cond_mac_seq
  import cond_mac_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int DEPTH = 5,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  input  logic [AW:0]      len,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  logic signed [WIDTH-1:0] a_mem_r [DEPTH];
  logic signed [WIDTH-1:0] b_mem_r [DEPTH];

  state_t                  state_r, state_s;
  logic signed [WIDTH-1:0] x_r, x_s;
  logic [AW-1:0]           idx_r, idx_s;
  logic [1:0]              mode_r, mode_s;
  logic [AW:0]             len_r, len_s, len_eff_s;
  logic [WIDTH-1:0]        result_r;
  logic                    busy_r, valid_r, mul_en_s, cond_s, last_s;
  logic signed [WIDTH-1:0] a_rd_s, b_rd_s, p_s, add_s, sub_s;

  assign a_rd_s    = a_mem_r[idx_r];
  assign b_rd_s    = b_mem_r[idx_r];
  assign cond_s    = (a_rd_s > x_r);
  assign last_s    = ({1'b0, idx_r} == (len_r - (AW+1)'(1)));
  assign len_eff_s = ((len == (AW+1)'(0)) || (len > (AW+1)'(DEPTH))) ? (AW+1)'(DEPTH) : len;

`ifdef COND_MAC_SAT_EN
  assign add_s = WIDTH'(sat_add(wide_t'(x_r), wide_t'(p_s), WIDTH));
  assign sub_s = WIDTH'(sat_sub(wide_t'(x_r), wide_t'(p_s), WIDTH));
`else
  assign add_s = x_r + p_s;
  assign sub_s = x_r - p_s;
`endif

  cond_mac_fxmul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_fxmul (
    .clk   (clk),
    .reset (reset),
    .en    (mul_en_s),
    .a     (a_rd_s),
    .b     (b_rd_s),
    .p     (p_s)
  );

  // Array write port; frozen while a run is in flight, out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_r && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
      if (wr_sel) begin
        b_mem_r[wr_addr] <= $signed(wr_data);
      end else begin
        a_mem_r[wr_addr] <= $signed(wr_data);
      end
    end
  end

  // Next-state and datapath update for the MUL/ACC loop.
  always_comb begin
    state_s  = state_r;
    x_s      = x_r;
    idx_s    = idx_r;
    mode_s   = mode_r;
    len_s    = len_r;
    mul_en_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          x_s     = $signed(c);
          mode_s  = mode;
          len_s   = len_eff_s;
          idx_s   = {AW{1'b0}};
          state_s = S_MUL;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MUL: begin
        mul_en_s = 1'b1;
        state_s  = S_ACC;
      end
      S_ACC: begin
        case (mode_r)
          MODE_ADDSUB:  x_s = cond_s ? add_s : sub_s;
          MODE_ADDHOLD: x_s = cond_s ? add_s : x_r;
          default:      x_s = add_s;
        endcase
        idx_s = idx_r + AW'(1);
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_MUL;
        end
      end
      S_DONE: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, working registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      x_r      <= {WIDTH{1'b0}};
      idx_r    <= {AW{1'b0}};
      mode_r   <= 2'd0;
      len_r    <= {(AW+1){1'b0}};
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      idx_r   <= idx_s;
      mode_r  <= mode_s;
      len_r   <= len_s;
      busy_r  <= (state_s == S_MUL) || (state_s == S_ACC);
      valid_r <= (state_s == S_DONE);
      if (state_s == S_DONE) begin
        result_r <= x_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign result = result_r;
  assign valid  = valid_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_cond_mac_seq.sv
// Directed self-checking bench for cond_mac_seq (DEPTH=5, FRAC=16) with hand-computed results.
module tb_cond_mac_seq;

  logic        clk = 1'b0;
  logic        reset, start, wr_en, wr_sel;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data, c;
  logic [1:0]  mode;
  logic [3:0]  len;
  logic [31:0] result;
  logic        valid, busy;

  int n_checks = 0;
  int n_fail   = 0;

  cond_mac_seq #(.WIDTH(32), .FRAC(16), .DEPTH(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .c       (c),
    .mode    (mode),
    .len     (len),
    .result  (result),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [2:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 5; i++) begin
      wr(1'b0, 3'(i), 32'((i + 1) * 65536));
      wr(1'b1, 3'(i), 32'((i + 7) * 65536));
    end
  endtask

  // Launch a run, check busy for ncyc cycles, then the one-cycle valid pulse.
  task automatic run(input string tag, input logic [1:0] m, input logic [3:0] l,
                     input int ncyc, input logic [31:0] exp, input logic start_in_done);
    mode = m; len = l; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check_eq({tag, "_novalid"}, {31'd0, valid}, 32'd0);
      tick();
    end
    check_eq({tag, "_valid"}, {31'd0, valid}, 32'd1);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_result"}, result, exp);
    start = start_in_done;
    tick();
    start = 1'b0;
    check_eq({tag, "_pulse_end"}, {31'd0, valid}, 32'd0);
    check_eq({tag, "_not_relaunched"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_hold"}, result, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_addr = 3'd0; wr_data = 32'd0; c = 32'd0; mode = 2'd0; len = 4'd0;
    tick(); tick();
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    load_seq();

    run("mac", 2'd0, 4'd0, 10, 32'd9502720, 1'b0);
    run("addsub", 2'd1, 4'd0, 10, 32'd2162688, 1'b1);
    run("addhold", 2'd2, 4'd0, 10, 32'd458752, 1'b0);
    run("mode3", 2'd3, 4'd0, 10, 32'd9502720, 1'b0);
    run("len2", 2'd0, 4'd2, 4, 32'd1507328, 1'b0);
    run("len7", 2'd0, 4'd7, 10, 32'd9502720, 1'b0);

    // Reset four cycles into a run aborts it.
    mode = 2'd0; len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_valid", {31'd0, valid}, 32'd0);
    check_eq("abort_result", result, 32'd0);
    run("after_abort", 2'd0, 4'd0, 10, 32'd9502720, 1'b0);

    // Start and a write to a[0] mid-run are both ignored.
    mode = 2'd0; len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 4; k <= 10; k++) tick();
    check_eq("midrun_valid", {31'd0, valid}, 32'd1);
    check_eq("midrun_result", result, 32'd9502720);
    tick();
    check_eq("midrun_no_queue", {31'd0, busy}, 32'd0);
    run("a0_kept", 2'd0, 4'd1, 2, 32'd458752, 1'b0);

    // Overflowing product: saturates or truncates depending on build.
    wr(1'b0, 3'd0, 32'h7FFF0000);
    wr(1'b1, 3'd0, 32'h7FFF0000);
    for (int i = 1; i < 5; i++) wr(1'b0, 3'(i), 32'd0);
`ifdef COND_MAC_SAT_EN
    run("ovf", 2'd0, 4'd0, 10, 32'h7FFFFFFF, 1'b0);
`else
    run("ovf", 2'd0, 4'd0, 10, 32'h00010000, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
